adder_subtracter_overflow: RTL and testbench
============================================

ADDER_SUBTRACTER_OVERFLOW -- requirements
Module: adder_subtracter_overflow

Interface
REQ-001 Parameter: n, default 8, operand/result width in bits; legal range n >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: x  input  n  first operand, two's complement or unsigned.
REQ-005 Port: y  input  n  second operand, two's complement or unsigned.
REQ-006 Port: cin  input  1  mode select and LSB carry-in: 0 = add (x + y), 1 = subtract (x - y).
REQ-007 Port: s  output  n  registered result, low n bits.
REQ-008 Port: cout  output  1  registered carry out of the MSB stage.
REQ-009 Port: overflow  output  1  registered signed-overflow flag.

Function
REQ-010 The datapath SHALL form y_eff = y XOR {n{cin}} and compute x + y_eff + cin through an n-stage ripple-carry chain.
REQ-011 cin=0: s SHALL equal (x + y) mod 2^n; cout SHALL equal the unsigned carry out.
REQ-012 cin=1: s SHALL equal (x - y) mod 2^n; cout SHALL equal the carry out of x + ~y + 1 (1 = no borrow, 0 = borrow).
REQ-013 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB, i.e. the signed result is not representable in n bits.
REQ-014 Latency SHALL be exactly 1 clock: outputs on cycle k+1 reflect x, y, cin sampled at rising edge k.
REQ-015 Outputs SHALL update every cycle with no enable or handshake; no input combinationally reaches any output.
REQ-016 Boundaries: n=8, x=0x7F, y=0x01, cin=0 -> s=0x80, cout=0, overflow=1; x=0x80, y=0x01, cin=1 -> s=0x7F, cout=1, overflow=1; x=0xFF, y=0x01, cin=0 -> s=0x00, cout=1, overflow=0.
REQ-017 Subtracting 0 (cin=1, y=0) SHALL give s=x, cout=1, overflow=0.
REQ-018 Subtracting the most-negative value (y=0x80 for n=8) SHALL set overflow exactly when x is non-negative.

Reset
REQ-019 When rst=1 at a rising edge, s, cout and overflow SHALL all be 0 on the following cycle, regardless of x, y, cin.
REQ-020 rst SHALL take priority over any input change in the same cycle; reset asserted mid-stream discards the in-flight result.
REQ-021 In the first cycle after rst deasserts, outputs SHALL reflect the inputs sampled at that edge; no extra warm-up cycles.
REQ-022 Before the first reset, output values are undefined; the bench SHALL apply reset before checking.

Structure
REQ-023 No shared package is required; n is the only parameter and the module SHALL need no typedefs or global constants.
REQ-024 One sub-module, full_adder (a, b, ci -> sum, co, purely combinational), SHALL be instantiated n times via a generate loop to form the carry chain.
REQ-025 The top level SHALL contain the XOR conditioning of y, the generate chain, the overflow XOR and one output register bank.

Verification
REQ-026 Reset: rst=1 for 2 cycles with x=0x55, y=0x11, cin=0 -> s=0, cout=0, overflow=0; release -> s=0x66 one cycle later.
REQ-027 Add then subtract: x=5, y=6, cin=0 -> s=11, cout=0, ov=0; then cin=1 -> s=0xFF (-1), cout=0, ov=0.
REQ-028 Negative operands: x=6, y=0xFD (-3), cin=1 -> s=9, cout=0, ov=0; x=4, y=0xFB (-5), cin=0 -> s=0xFF (-1), cout=0, ov=0.
REQ-029 Overflow corners: the three REQ-016 cases, each checked one cycle after application.
REQ-030 Random: at least 10,000 random (x, y, cin) vectors at n=8 and n=4, compared against a reference model of REQ-011..REQ-013 with 1-cycle delay, including reset pulses at random cycles (REQ-019/020).

Source files
------------

// File: rtl/adder_subtracter_overflow_full_adder.sv
// One-bit full adder cell; instantiated once per bit of the carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_subtracter_overflow.sv
// Registered n-bit ripple-carry adder/subtracter with unsigned carry-out and signed-overflow flag.
// cin selects the mode and doubles as the LSB carry-in, so subtraction is x + ~y + 1.
module adder_subtracter_overflow #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         overflow
);

    logic [n-1:0] y_eff;
    logic [n-1:0] sum;
    logic [n:0]   carry;

    logic [n-1:0] s_d, s_q;
    logic         cout_d, cout_q;
    logic         overflow_d, overflow_q;

    assign y_eff    = y ^ {n{cin}};
    assign carry[0] = cin;

    for (genvar i = 0; i < int'(n); i++) begin : g_chain
        full_adder u_fa (
            .a   (x[i]),
            .b   (y_eff[i]),
            .ci  (carry[i]),
            .sum (sum[i]),
            .co  (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    always_comb begin
        s_d        = sum;
        cout_d     = carry[n];
        overflow_d = carry[n] ^ carry[n-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign s        = s_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adder_subtracter_overflow.sv
// Scoreboard bench: drives an 8-bit and a 4-bit instance side by side, queues expected
// results at issue time and lets one monitor pop and compare them a cycle later.
module tb_adder_subtracter_overflow;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x8, y8;
    logic [3:0] x4, y4;
    logic       cin;
    logic [7:0] s8;
    logic [3:0] s4;
    logic       cout8, ov8, cout4, ov4;

    exp_t q8[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    adder_subtracter_overflow #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .x(x8), .y(y8), .cin(cin),
        .s(s8), .cout(cout8), .overflow(ov8)
    );

    adder_subtracter_overflow #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .x(x4), .y(y4), .cin(cin),
        .s(s4), .cout(cout4), .overflow(ov4)
    );

    // Reference from the arithmetic definition: signed-range test and unsigned compare.
    function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b, logic c, logic r);
        exp_t e;
        int mask, ai, bi, res, sa, sb, ss;
        e = '0;
        if (r) return e;
        mask = (1 << w) - 1;
        ai   = int'(a) & mask;
        bi   = int'(b) & mask;
        res  = c ? (ai - bi) : (ai + bi);
        sa   = (ai >> (w - 1)) & 1;
        sb   = (bi >> (w - 1)) & 1;
        ss   = ((res & mask) >> (w - 1)) & 1;
        e.s  = 8'(res & mask);
        e.c  = c ? (ai >= bi) : (res > mask);
        e.ov = c ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return e;
    endfunction

    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input exp_t e8);
        @(negedge clk);
        #1;
        rst = r;
        x8  = a;
        y8  = b;
        x4  = a[3:0];
        y4  = b[3:0];
        cin = c;
        q8.push_back(e8);
        q4.push_back(model(4, a, b, c, r));
    endtask

    task automatic apply_m(input logic r, input logic [7:0] a, input logic [7:0] b, input logic c);
        apply(r, a, b, c, model(8, a, b, c, r));
    endtask

    function automatic exp_t mk(logic [7:0] sv, logic cv, logic ovv);
        exp_t e;
        e.s  = sv;
        e.c  = cv;
        e.ov = ovv;
        return e;
    endfunction

    // Monitor: outputs are presented every cycle, so each negedge retires one queued item.
    always @(negedge clk) begin
        exp_t e;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            n_checks++;
            if (s8 === e.s && cout8 === e.c && ov8 === e.ov) n_pass++;
            else $display("FAIL n8 got s=%h cout=%b ov=%b, want s=%h cout=%b ov=%b",
                          s8, cout8, ov8, e.s, e.c, e.ov);
        end
        if (q4.size() > 0) begin
            e = q4.pop_front();
            n_checks++;
            if (s4 === e.s[3:0] && cout4 === e.c && ov4 === e.ov) n_pass++;
            else $display("FAIL n4 got s=%h cout=%b ov=%b, want s=%h cout=%b ov=%b",
                          s4, cout4, ov4, e.s[3:0], e.c, e.ov);
        end
    end

    initial begin
        rst = 1'b1; x8 = '0; y8 = '0; x4 = '0; y4 = '0; cin = 1'b0;

        // Reset holds outputs at zero, release shows the sampled sum immediately.
        apply(1'b1, 8'h55, 8'h11, 1'b0, mk(8'h00, 1'b0, 1'b0));
        apply(1'b1, 8'h55, 8'h11, 1'b0, mk(8'h00, 1'b0, 1'b0));
        apply(1'b0, 8'h55, 8'h11, 1'b0, mk(8'h66, 1'b0, 1'b0));
        // Add then subtract, negative operands.
        apply(1'b0, 8'h05, 8'h06, 1'b0, mk(8'h0B, 1'b0, 1'b0));
        apply(1'b0, 8'h05, 8'h06, 1'b1, mk(8'hFF, 1'b0, 1'b0));
        apply(1'b0, 8'h06, 8'hFD, 1'b1, mk(8'h09, 1'b0, 1'b0));
        apply(1'b0, 8'h04, 8'hFB, 1'b0, mk(8'hFF, 1'b0, 1'b0));
        // Overflow corners.
        apply(1'b0, 8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1));
        apply(1'b0, 8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b1, 1'b1));
        apply(1'b0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0));
        // Subtract zero, subtract most-negative.
        apply(1'b0, 8'h3C, 8'h00, 1'b1, mk(8'h3C, 1'b1, 1'b0));
        apply(1'b0, 8'h00, 8'h80, 1'b1, mk(8'h80, 1'b0, 1'b1));
        apply(1'b0, 8'h7F, 8'h80, 1'b1, mk(8'hFF, 1'b0, 1'b1));
        apply(1'b0, 8'hFF, 8'h80, 1'b1, mk(8'h7F, 1'b1, 1'b0));
        apply(1'b0, 8'h80, 8'h80, 1'b1, mk(8'h00, 1'b1, 1'b0));
        // Mid-stream reset discards the in-flight result.
        apply(1'b0, 8'h40, 8'h40, 1'b0, mk(8'h80, 1'b0, 1'b1));
        apply(1'b1, 8'h7F, 8'h7F, 1'b0, mk(8'h00, 1'b0, 1'b0));
        apply(1'b0, 8'h01, 8'h01, 1'b0, mk(8'h02, 1'b0, 1'b0));

        for (int i = 0; i < 10000; i++) begin
            apply_m(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                    8'($urandom), 8'($urandom), 1'($urandom));
        end
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (stim_done && q8.size() == 0 && q4.size() == 0) n_pass++;
        else $display("FAIL drain got done=%0b q8=%0d q4=%0d, want done=1 q8=0 q4=0",
                      stim_done, q8.size(), q4.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
